tl_initiator: RTL

//  Single-outstanding TileLink-UL initiator: turns a simple req/rsp port into Get and PutFullData

---
 rtl/tl_initiator_if.sv | 38 +++
 rtl/tl_initiator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tl_initiator_if.sv
// TileLink-UL A/D channel bundle (64-bit data, 8-bit source) for a single initiator/responder pair.
interface tl_initiator_if;
   logic        a_valid;
   logic        a_ready;
   logic [2:0]  a_opcode;
   logic [2:0]  a_param;
   logic [2:0]  a_size;
   logic [7:0]  a_source;
   logic [63:0] a_address;
   logic [7:0]  a_mask;
   logic [63:0] a_data;
   logic        a_corrupt;

   logic        d_valid;
   logic        d_ready;
   logic [2:0]  d_opcode;
   logic [1:0]  d_param;
   logic [2:0]  d_size;
   logic [7:0]  d_source;
   logic        d_sink;
   logic        d_denied;
   logic [63:0] d_data;
   logic        d_corrupt;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      output d_ready,
      input  a_ready,
      input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      input  d_ready,
      output a_ready,
      output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
   );
endinterface

// File: rtl/tl_initiator.sv
// Single-outstanding TileLink-UL initiator: req/rsp port to Get/PutFullData with alignment
// checking, D-channel source matching and a response timeout.
module tl_initiator #(
   parameter logic [7:0]  SOURCE_ID = 8'd0,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [63:0]   req_addr,
   input  logic [1:0]    req_size,
   input  logic [63:0]   req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [63:0]   rsp_rdata,
   output logic          rsp_err,
   tl_initiator_if.master bus
);

   localparam logic [2:0] TlGet         = 3'd4;
   localparam logic [2:0] TlPutFullData = 3'd0;

   typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

   state_e      state_q, state_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [63:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic        a_valid_q, a_valid_d;
   logic        d_ready_q, d_ready_d;
   logic [2:0]  a_opcode_q, a_opcode_d;
   logic [2:0]  a_size_q, a_size_d;
   logic [7:0]  a_source_q, a_source_d;
   logic [63:0] a_address_q, a_address_d;
   logic [7:0]  a_mask_q, a_mask_d;
   logic [63:0] a_data_q, a_data_d;
   logic [31:0] cnt_q, cnt_d;

   function automatic logic [7:0] size_to_mask(logic [1:0] size);
      unique case (size)
         2'd0:    return 8'h01;
         2'd1:    return 8'h03;
         2'd2:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [63:0] expand_mask(logic [7:0] m);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{m[i]}};
      return r;
   endfunction

   function automatic logic misaligned(logic [2:0] lsb, logic [1:0] size);
      unique case (size)
         2'd0:    return 1'b0;
         2'd1:    return lsb[0];
         2'd2:    return |lsb[1:0];
         default: return |lsb;
      endcase
   endfunction

   logic d_hit, timed_out;
   assign d_hit     = bus.d_valid && d_ready_q && (bus.d_source == SOURCE_ID);
   assign timed_out = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      a_valid_d   = a_valid_q;
      d_ready_d   = d_ready_q;
      a_opcode_d  = a_opcode_q;
      a_size_d    = a_size_q;
      a_source_d  = a_source_q;
      a_address_d = a_address_q;
      a_mask_d    = a_mask_q;
      a_data_d    = a_data_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               a_opcode_d  = req_write ? TlPutFullData : TlGet;
               a_size_d    = {1'b0, req_size};
               a_source_d  = SOURCE_ID;
               a_address_d = req_addr;
               a_mask_d    = size_to_mask(req_size);
               a_data_d    = req_write ? (req_wdata & expand_mask(size_to_mask(req_size))) : '0;
               cnt_d       = '0;
               if (misaligned(req_addr[2:0], req_size)) begin
                  state_d     = StDone;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  state_d   = StReq;
                  a_valid_d = 1'b1;
               end
            end
         end
         StReq: begin
            if (bus.a_ready) begin
               a_valid_d = 1'b0;
               d_ready_d = 1'b1;
               state_d   = StResp;
            end
         end
         StResp: begin
            // A matching D beat takes priority over timeout expiry in the same cycle
            if (d_hit) begin
               rsp_rdata_d = (a_opcode_q == TlGet) ? (bus.d_data & expand_mask(a_mask_q)) : '0;
               rsp_err_d   = bus.d_denied | bus.d_corrupt;
               rsp_valid_d = 1'b1;
               d_ready_d   = 1'b0;
               state_d     = StDone;
            end else if (timed_out) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               d_ready_d   = 1'b0;
               state_d     = StDone;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StDone: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         a_valid_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         a_opcode_q  <= '0;
         a_size_q    <= '0;
         a_source_q  <= '0;
         a_address_q <= '0;
         a_mask_q    <= '0;
         a_data_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         a_valid_q   <= a_valid_d;
         d_ready_q   <= d_ready_d;
         a_opcode_q  <= a_opcode_d;
         a_size_q    <= a_size_d;
         a_source_q  <= a_source_d;
         a_address_q <= a_address_d;
         a_mask_q    <= a_mask_d;
         a_data_q    <= a_data_d;
         cnt_q       <= cnt_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_err       = rsp_err_q;
   assign bus.a_valid   = a_valid_q;
   assign bus.a_opcode  = a_opcode_q;
   assign bus.a_param   = '0;
   assign bus.a_size    = a_size_q;
   assign bus.a_source  = a_source_q;
   assign bus.a_address = a_address_q;
   assign bus.a_mask    = a_mask_q;
   assign bus.a_data    = a_data_q;
   assign bus.a_corrupt = 1'b0;
   assign bus.d_ready   = d_ready_q;

   // d_opcode is deliberately not checked; the other D fields carry nothing we need
   logic unused_d;
   assign unused_d = ^{bus.d_opcode, bus.d_param, bus.d_size, bus.d_sink};

endmodule
